// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle MIPS datapath and its sequencer.
// The controller takes the slave side; the datapath (or a bench) takes the master side.
interface multicycle_controller_if #(
   parameter int ALUCTRL_W = 4
);
   logic [5:0]           opcode;
   logic [5:0]           funct;
   logic                 zero;
   logic                 mem_ready;
   logic                 ir_write;
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 mem_read;
   logic                 mem_write;
   logic                 half;
   logic                 reg_write;
   logic [1:0]           reg_dst;
   logic [1:0]           mem_to_reg;
   logic                 alu_src;
   logic [ALUCTRL_W-1:0] alu_ctrl;
   logic                 illegal;
   logic                 bus_err;
   logic [2:0]           state;

   modport slave (
      input  opcode, funct, zero, mem_ready,
      output ir_write, pc_write, pc_src, mem_read, mem_write, half, reg_write,
             reg_dst, mem_to_reg, alu_src, alu_ctrl, illegal, bus_err, state
   );

   modport master (
      output opcode, funct, zero, mem_ready,
      input  ir_write, pc_write, pc_src, mem_read, mem_write, half, reg_write,
             reg_dst, mem_to_reg, alu_src, alu_ctrl, illegal, bus_err, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Five-phase sequencer (fetch/decode/exec/mem/wb) for the multi-cycle MIPS datapath.
// Define MC_HALFWORD_EN to decode lh/sh and drive the half strobe in MEM.
module multicycle_controller #(
   parameter int ALUCTRL_W = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic clk,
   input  logic rst,
   multicycle_controller_if.slave io_bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
   } state_t;

   typedef enum logic [4:0] {
      C_NONE, C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_SLL, C_SRL,
      C_ADDI, C_ANDI, C_SLTI, C_LW, C_SW, C_LH, C_SH, C_BEQ, C_BNE,
      C_J, C_JAL, C_JR, C_JALR, C_ILLEGAL
   } class_t;

   state_t           r_state;
   class_t           r_class;
   logic [CNT_W-1:0] r_waitCnt;
   logic             r_illegal;
   logic             r_busErr;

   class_t               w_decClass;
   logic                 w_waitLast;
   logic                 w_irWrite, w_pcWrite, w_memRead, w_memWrite, w_half;
   logic                 w_regWrite, w_aluSrc;
   logic [1:0]           w_pcSrc, w_regDst, w_memToReg;
   logic [ALUCTRL_W-1:0] w_aluCtrl;

   function automatic class_t decodeClass(input logic [5:0] op, input logic [5:0] fn);
      class_t c;
      c = C_ILLEGAL;
      case (op)
         6'b000000: begin
            case (fn)
               6'b100000: c = C_ADD;
               6'b100010: c = C_SUB;
               6'b100100: c = C_AND;
               6'b100101: c = C_OR;
               6'b100110: c = C_XOR;
               6'b100111: c = C_NOR;
               6'b101010: c = C_SLT;
               6'b000000: c = C_SLL;
               6'b000010: c = C_SRL;
               6'b001000: c = C_JR;
               6'b001001: c = C_JALR;
               default:   c = C_ILLEGAL;
            endcase
         end
         6'b000010: c = C_J;
         6'b000011: c = C_JAL;
         6'b000100: c = C_BEQ;
         6'b000101: c = C_BNE;
         6'b001000: c = C_ADDI;
         6'b001100: c = C_ANDI;
         6'b001010: c = C_SLTI;
         6'b100011: c = C_LW;
         6'b101011: c = C_SW;
`ifdef MC_HALFWORD_EN
         6'b100001: c = C_LH;
         6'b101001: c = C_SH;
`endif
         default:   c = C_ILLEGAL;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] aluCode(input class_t c);
      case (c)
         C_ADD, C_ADDI, C_LW, C_SW, C_LH, C_SH: aluCode = 4'b0010;
         C_SUB, C_BEQ:                          aluCode = 4'b0110;
         C_AND, C_ANDI:                         aluCode = 4'b0000;
         C_OR:                                  aluCode = 4'b0001;
         C_XOR:                                 aluCode = 4'b0011;
         C_NOR:                                 aluCode = 4'b1100;
         C_SLT, C_SLTI:                         aluCode = 4'b0111;
         C_SLL:                                 aluCode = 4'b1000;
         C_SRL:                                 aluCode = 4'b1001;
         C_BNE:                                 aluCode = 4'b1110;
         default:                               aluCode = 4'b0000;
      endcase
   endfunction

   function automatic logic isLoad(input class_t c);
      return c inside {C_LW, C_LH};
   endfunction

   function automatic logic isStore(input class_t c);
      return c inside {C_SW, C_SH};
   endfunction

   function automatic logic isImm(input class_t c);
      return c inside {C_ADDI, C_ANDI, C_SLTI, C_LW, C_SW, C_LH, C_SH};
   endfunction

   function automatic logic isRAlu(input class_t c);
      return c inside {C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_SLL, C_SRL};
   endfunction

   assign w_decClass = decodeClass(io_bus.opcode, io_bus.funct);
   assign w_waitLast = (r_waitCnt == CNT_W'(TIMEOUT - 1));

   // The wait counter is cleared on every transition into FETCH or MEM, so it
   // always counts wait states of the current memory access only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_class   <= C_NONE;
         r_waitCnt <= '0;
         r_illegal <= 1'b0;
         r_busErr  <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (io_bus.mem_ready) begin
                  r_state <= S_DECODE;
               end else if (w_waitLast) begin
                  r_state  <= S_HALT;
                  r_busErr <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + CNT_W'(1);
               end
            end
            S_DECODE: begin
               r_class <= w_decClass;
               case (w_decClass)
                  C_J, C_JAL, C_JR, C_JALR: begin
                     r_state   <= S_FETCH;
                     r_waitCnt <= '0;
                  end
                  C_ILLEGAL: begin
                     r_state   <= S_HALT;
                     r_illegal <= 1'b1;
                  end
                  default: r_state <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               if (r_class inside {C_BEQ, C_BNE}) begin
                  r_state   <= S_FETCH;
                  r_waitCnt <= '0;
               end else if (isLoad(r_class) || isStore(r_class)) begin
                  r_state   <= S_MEM;
                  r_waitCnt <= '0;
               end else begin
                  r_state <= S_WB;
               end
            end
            S_MEM: begin
               if (io_bus.mem_ready) begin
                  r_state   <= isLoad(r_class) ? S_WB : S_FETCH;
                  r_waitCnt <= '0;
               end else if (w_waitLast) begin
                  r_state  <= S_HALT;
                  r_busErr <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + CNT_W'(1);
               end
            end
            S_WB: begin
               r_state   <= S_FETCH;
               r_waitCnt <= '0;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // DECODE strobes come straight from the live opcode; later phases use the
   // class captured at the end of DECODE so IR changes are ignored.
   always_comb begin
      w_irWrite  = 1'b0;
      w_pcWrite  = 1'b0;
      w_pcSrc    = 2'b00;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      w_half     = 1'b0;
      w_regWrite = 1'b0;
      w_regDst   = 2'b00;
      w_memToReg = 2'b00;
      w_aluSrc   = 1'b0;
      w_aluCtrl  = '0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               w_memRead = 1'b1;
               if (io_bus.mem_ready) begin
                  w_irWrite = 1'b1;
                  w_pcWrite = 1'b1;
               end
            end
            S_DECODE: begin
               case (w_decClass)
                  C_J: begin
                     w_pcWrite = 1'b1;
                     w_pcSrc   = 2'b10;
                  end
                  C_JAL: begin
                     w_pcWrite  = 1'b1;
                     w_pcSrc    = 2'b10;
                     w_regWrite = 1'b1;
                     w_regDst   = 2'b10;
                     w_memToReg = 2'b10;
                  end
                  C_JR: begin
                     w_pcWrite = 1'b1;
                     w_pcSrc   = 2'b11;
                  end
                  C_JALR: begin
                     w_pcWrite  = 1'b1;
                     w_pcSrc    = 2'b11;
                     w_regWrite = 1'b1;
                     w_regDst   = 2'b01;
                     w_memToReg = 2'b10;
                  end
                  default: ;
               endcase
            end
            S_EXEC: begin
               w_aluCtrl = ALUCTRL_W'(aluCode(r_class));
               w_aluSrc  = isImm(r_class);
               if (r_class == C_BEQ) begin
                  w_pcWrite = io_bus.zero;
                  w_pcSrc   = 2'b01;
               end else if (r_class == C_BNE) begin
                  w_pcWrite = !io_bus.zero;
                  w_pcSrc   = 2'b01;
               end
            end
            S_MEM: begin
               w_aluSrc   = 1'b1;
               w_aluCtrl  = ALUCTRL_W'(4'b0010);
               w_memRead  = isLoad(r_class);
               w_memWrite = isStore(r_class);
`ifdef MC_HALFWORD_EN
               w_half     = (r_class == C_LH) || (r_class == C_SH);
`else
               w_half     = 1'b0;
`endif
            end
            S_WB: begin
               w_regWrite = 1'b1;
               w_regDst   = isRAlu(r_class) ? 2'b01 : 2'b00;
               w_memToReg = isLoad(r_class) ? 2'b01 : 2'b00;
               w_aluCtrl  = ALUCTRL_W'(aluCode(r_class));
               w_aluSrc   = isImm(r_class);
            end
            default: ;
         endcase
      end
   end

   assign io_bus.ir_write   = w_irWrite;
   assign io_bus.pc_write   = w_pcWrite;
   assign io_bus.pc_src     = w_pcSrc;
   assign io_bus.mem_read   = w_memRead;
   assign io_bus.mem_write  = w_memWrite;
   assign io_bus.half       = w_half;
   assign io_bus.reg_write  = w_regWrite;
   assign io_bus.reg_dst    = w_regDst;
   assign io_bus.mem_to_reg = w_memToReg;
   assign io_bus.alu_src    = w_aluSrc;
   assign io_bus.alu_ctrl   = w_aluCtrl;
   assign io_bus.illegal    = r_illegal;
   assign io_bus.bus_err    = r_busErr;
   assign io_bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes the per-cycle
// expected outputs derived from an instruction table; a negedge monitor pops and compares.
module tb_multicycle_controller;
   localparam int ALUCTRL_W = 4;
   localparam int TIMEOUT   = 16;

   localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BEQ = 4, K_BNE = 5;
   localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_ILL = 10;

   // Phase numbers 0..5 equal the architectural state codes; 6/7 mark reset cycles.
   localparam int P_RST_FIRST = 6, P_RST = 7;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int         kind;
      logic [3:0] alu;
      logic       half;
   } instr_t;

   typedef struct {
      logic [16:0] strobes;
      logic [2:0]  state;
      logic        illegal;
      logic        busErr;
      logic        chkState;
      int          phase;
      logic [5:0]  op;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     nCompared = 0;
   int     nMismatched = 0;
   exp_t   expQ[$];
   instr_t tbl[$];
   logic   tbIllegal = 1'b0;
   logic   tbBusErr  = 1'b0;
   logic   tbHalted  = 1'b0;

   always #5 clk = ~clk;

   multicycle_controller_if #(.ALUCTRL_W(ALUCTRL_W)) bus ();

   multicycle_controller #(.ALUCTRL_W(ALUCTRL_W), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   function automatic instr_t mkInstr(logic [5:0] op, logic [5:0] fn, int kind,
                                      logic [3:0] alu, logic half);
      instr_t r;
      r.op = op; r.fn = fn; r.kind = kind; r.alu = alu; r.half = half;
      return r;
   endfunction

   // Legal encodings come only from the table; anything else is illegal.
   function automatic instr_t lookup(logic [5:0] op, logic [5:0] fn);
      instr_t r;
      r = mkInstr(op, fn, K_ILL, 4'b0000, 1'b0);
      foreach (tbl[i]) begin
         if (tbl[i].op == op && (op != 6'd0 || tbl[i].fn == fn)) begin
            r = tbl[i];
            r.fn = fn;
         end
      end
      return r;
   endfunction

   function automatic exp_t mkExp(int phase, instr_t ins, logic rdy, logic z);
      exp_t       e;
      logic       irW, pcW, mr, mw, hf, rw, as;
      logic [1:0] ps, rd, m2r;
      logic [3:0] alu;
      logic       imm;
      irW = 0; pcW = 0; mr = 0; mw = 0; hf = 0; rw = 0; as = 0;
      ps = 0; rd = 0; m2r = 0; alu = 0;
      imm = (ins.kind == K_I) || (ins.kind == K_LOAD) || (ins.kind == K_STORE);
      case (phase)
         0: begin
            mr = 1;
            if (rdy) begin irW = 1; pcW = 1; end
         end
         1: begin
            if (ins.kind == K_J || ins.kind == K_JAL) begin pcW = 1; ps = 2'b10; end
            if (ins.kind == K_JR || ins.kind == K_JALR) begin pcW = 1; ps = 2'b11; end
            if (ins.kind == K_JAL)  begin rw = 1; rd = 2'b10; m2r = 2'b10; end
            if (ins.kind == K_JALR) begin rw = 1; rd = 2'b01; m2r = 2'b10; end
         end
         2: begin
            alu = ins.alu;
            as  = imm;
            if (ins.kind == K_BEQ) begin pcW = z;  ps = 2'b01; end
            if (ins.kind == K_BNE) begin pcW = !z; ps = 2'b01; end
         end
         3: begin
            as  = 1;
            alu = 4'b0010;
            mr  = (ins.kind == K_LOAD);
            mw  = (ins.kind == K_STORE);
            hf  = ins.half;
         end
         4: begin
            rw  = 1;
            rd  = (ins.kind == K_R) ? 2'b01 : 2'b00;
            m2r = (ins.kind == K_LOAD) ? 2'b01 : 2'b00;
            alu = ins.alu;
            as  = imm;
         end
         default: ;
      endcase
      e.strobes  = {irW, pcW, ps, mr, mw, hf, rw, rd, m2r, as, alu};
      e.state    = (phase <= 5) ? 3'(phase) : 3'd0;
      e.illegal  = tbIllegal;
      e.busErr   = tbBusErr;
      e.chkState = (phase != P_RST_FIRST);
      e.phase    = phase;
      e.op       = ins.op;
      return e;
   endfunction

   task automatic checkOutput(exp_t e);
      logic [16:0] act;
      logic [4:0]  actSt, expSt;
      act = {bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_read, bus.mem_write,
             bus.half, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.alu_ctrl};
      actSt = {bus.state, bus.illegal, bus.bus_err};
      expSt = {e.state, e.illegal, e.busErr};
      nCompared++;
      if (act !== e.strobes || (e.chkState && actSt !== expSt)) begin
         nMismatched++;
         $display("[TB] FAIL phase%0d op=%b t=%0t: got state=%0d illegal=%b bus_err=%b strobes=%05h, need state=%0d illegal=%b bus_err=%b strobes=%05h (state checked=%b)",
                  e.phase, e.op, $time, bus.state, bus.illegal, bus.bus_err, act,
                  e.state, e.illegal, e.busErr, e.strobes, e.chkState);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   // One clock of stimulus: opcode/funct carry the instruction only in DECODE.
   task automatic step(int phase, instr_t ins, bit decodeCycle, logic rdy, int zSel);
      logic z;
      z = (zSel < 0) ? 1'($urandom_range(0, 1)) : (zSel != 0);
      bus.mem_ready = rdy;
      bus.zero      = z;
      if (decodeCycle) begin
         bus.opcode = ins.op;
         bus.funct  = (ins.op == 6'd0) ? ins.fn : 6'($urandom);
      end else begin
         bus.opcode = 6'($urandom);
         bus.funct  = 6'($urandom);
      end
      expQ.push_back(mkExp(phase, ins, rdy, z));
      @(posedge clk);
      #1;
   endtask

   task automatic memPhase(int phase, instr_t ins, int waits);
      int low;
      low = (waits < TIMEOUT) ? waits : TIMEOUT;
      for (int i = 0; i < low; i++) step(phase, ins, 1'b0, 1'b0, -1);
      if (waits >= TIMEOUT) begin
         tbBusErr = 1'b1;
         tbHalted = 1'b1;
      end else begin
         step(phase, ins, 1'b0, 1'b1, -1);
      end
   endtask

   task automatic applyStimulus(instr_t ins, int fWait, int mWait, int zSel);
      memPhase(0, ins, fWait);
      if (tbHalted) return;
      step(1, ins, 1'b1, 1'($urandom_range(0, 1)), -1);
      if (ins.kind == K_J || ins.kind == K_JAL || ins.kind == K_JR || ins.kind == K_JALR) return;
      if (ins.kind == K_ILL) begin
         tbIllegal = 1'b1;
         tbHalted  = 1'b1;
         return;
      end
      step(2, ins, 1'b0, 1'($urandom_range(0, 1)), zSel);
      if (ins.kind == K_BEQ || ins.kind == K_BNE) return;
      if (ins.kind == K_LOAD || ins.kind == K_STORE) begin
         memPhase(3, ins, mWait);
         if (tbHalted || ins.kind == K_STORE) return;
      end
      step(4, ins, 1'b0, 1'($urandom_range(0, 1)), -1);
   endtask

   task automatic holdHalt(int n);
      instr_t none;
      none = mkInstr(6'd0, 6'd0, K_ILL, 4'd0, 1'b0);
      for (int i = 0; i < n; i++) step(5, none, 1'b0, 1'($urandom_range(0, 1)), -1);
   endtask

   task automatic doReset(int n);
      instr_t none;
      none = mkInstr(6'd0, 6'd0, K_ILL, 4'd0, 1'b0);
      rst = 1'b1;
      step(P_RST_FIRST, none, 1'b0, 1'($urandom_range(0, 1)), -1);
      tbIllegal = 1'b0;
      tbBusErr  = 1'b0;
      tbHalted  = 1'b0;
      for (int i = 1; i < n; i++) step(P_RST, none, 1'b0, 1'($urandom_range(0, 1)), -1);
      rst = 1'b0;
   endtask

   initial begin
      instr_t ins, lw, add;
      int     fW, mW;
      bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

      tbl.push_back(mkInstr(6'b000000, 6'b100000, K_R,     4'b0010, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b100010, K_R,     4'b0110, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b100100, K_R,     4'b0000, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b100101, K_R,     4'b0001, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b100110, K_R,     4'b0011, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b100111, K_R,     4'b1100, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b101010, K_R,     4'b0111, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b000000, K_R,     4'b1000, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b000010, K_R,     4'b1001, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b001000, K_JR,    4'b0000, 1'b0));
      tbl.push_back(mkInstr(6'b000000, 6'b001001, K_JALR,  4'b0000, 1'b0));
      tbl.push_back(mkInstr(6'b000010, 6'b000000, K_J,     4'b0000, 1'b0));
      tbl.push_back(mkInstr(6'b000011, 6'b000000, K_JAL,   4'b0000, 1'b0));
      tbl.push_back(mkInstr(6'b000100, 6'b000000, K_BEQ,   4'b0110, 1'b0));
      tbl.push_back(mkInstr(6'b000101, 6'b000000, K_BNE,   4'b1110, 1'b0));
      tbl.push_back(mkInstr(6'b001000, 6'b000000, K_I,     4'b0010, 1'b0));
      tbl.push_back(mkInstr(6'b001100, 6'b000000, K_I,     4'b0000, 1'b0));
      tbl.push_back(mkInstr(6'b001010, 6'b000000, K_I,     4'b0111, 1'b0));
      tbl.push_back(mkInstr(6'b100011, 6'b000000, K_LOAD,  4'b0010, 1'b0));
      tbl.push_back(mkInstr(6'b101011, 6'b000000, K_STORE, 4'b0010, 1'b0));
`ifdef MC_HALFWORD_EN
      tbl.push_back(mkInstr(6'b100001, 6'b000000, K_LOAD,  4'b0010, 1'b1));
      tbl.push_back(mkInstr(6'b101001, 6'b000000, K_STORE, 4'b0010, 1'b1));
`endif

      @(posedge clk);
      #1;
      doReset(3);

      add = lookup(6'b000000, 6'b100000);
      lw  = lookup(6'b100011, 6'b000000);
      applyStimulus(add, 0, 0, -1);
      applyStimulus(lw, 0, 3, -1);
      applyStimulus(lookup(6'b000100, 6'd0), 0, 0, 1);
      applyStimulus(lookup(6'b000101, 6'd0), 0, 0, 1);
      applyStimulus(lookup(6'b000011, 6'd0), 0, 0, -1);
      applyStimulus(lookup(6'b000000, 6'b001001), 1, 0, -1);
      applyStimulus(lookup(6'b000000, 6'b001000), 0, 0, -1);
      applyStimulus(lookup(6'b101011, 6'd0), TIMEOUT - 1, TIMEOUT - 1, -1);

      // Bus time-out in FETCH, then in MEM; both stay halted until reset.
      applyStimulus(add, TIMEOUT, 0, -1);
      holdHalt(4);
      doReset(2);
      applyStimulus(lw, 0, TIMEOUT, -1);
      holdHalt(3);
      doReset(2);

      applyStimulus(lookup(6'b111111, 6'($urandom)), 0, 0, -1);
      holdHalt(3);
      doReset(2);

      ins = lookup(6'b101001, 6'd0);
      applyStimulus(ins, 0, 1, -1);
      if (tbHalted) begin holdHalt(2); doReset(2); end
      ins = lookup(6'b100001, 6'd0);
      applyStimulus(ins, 0, 0, -1);
      if (tbHalted) begin holdHalt(2); doReset(2); end

      // Abort a load between EXEC and MEM; the next instruction must start clean.
      memPhase(0, lw, 0);
      step(1, lw, 1'b1, 1'b1, -1);
      step(2, lw, 1'b0, 1'b1, -1);
      doReset(2);
      applyStimulus(add, 0, 0, -1);

      for (int n = 0; n < 90; n++) begin
         if ($urandom_range(0, 9) == 0) ins = lookup(6'($urandom), 6'($urandom));
         else ins = tbl[$urandom_range(0, tbl.size() - 1)];
         fW = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         mW = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         if ($urandom_range(0, 24) == 0) fW = TIMEOUT - 1 + int'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) mW = TIMEOUT - 1 + int'($urandom_range(0, 1));
         applyStimulus(ins, fW, mW, -1);
         if (tbHalted) begin
            holdHalt(2);
            doReset(2);
         end
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
